// File: rtl/rs232_pkg.sv
// Shared encodings and baud helpers for the RS232 test link (RX and TX sides).
package rs232_pkg;

  typedef enum logic [1:0] {
    RxIdle,
    RxStart,
    RxData,
    RxStop
  } rx_state_e;

  typedef enum logic {
    ChkHunt,
    ChkLocked
  } chk_state_e;

  // Clock cycles per bit, integer-truncated.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    return clk_hz / baud;
  endfunction

  // Cycles from the start edge to the mid-start-bit check.
  function automatic int unsigned calc_half_div(input int unsigned clk_hz,
                                                input int unsigned baud);
    return calc_div(clk_hz, baud) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: RXD synchroniser, baud counter, RX FSM and shift register.
module uart_rx_core
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50000000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       frame_err_o
);

  localparam int unsigned Div  = calc_div(CLK_HZ, BAUD);
  localparam int unsigned Half = calc_half_div(CLK_HZ, BAUD);
  localparam int unsigned CntW = $clog2(Div);

  logic [1:0]      sync_q;
  logic [1:0]      flush_q;
  logic            prev_line_q;
  logic            line;
  logic            fall;
  rx_state_e       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            ferr_q, ferr_d;

  assign line = sync_q[1];
  // prev_line_q stays 0 until the synchroniser has flushed its reset value, so a line that
  // is low when reset releases must first go high before a start edge can be seen.
  assign fall = prev_line_q & ~line;

  // Synchroniser and start-edge history.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 2'b11;
      flush_q     <= 2'b00;
      prev_line_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rxd_i};
      flush_q     <= {flush_q[0], 1'b1};
      if (flush_q[1]) begin
        prev_line_q <= line;
      end
    end
  end

  // RX FSM state and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RxIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state: half-bit start check, 8 LSB-first data samples, stop-bit sample.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CntW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      RxIdle: begin
        cnt_d = '0;
        if (fall) begin
          state_d = RxStart;
        end
      end
      RxStart: begin
        if (cnt_q == CntW'(Half - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = line ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (cnt_q == CntW'(Div - 1)) begin
          cnt_d   = '0;
          shift_d = {line, shift_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = RxStop;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      RxStop: begin
        if (cnt_q == CntW'(Div - 1)) begin
          cnt_d   = '0;
          state_d = RxIdle;
          if (line) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RxIdle;
    endcase
  end

  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;

endmodule

// File: rtl/uart_rx_ramp_checker.sv
// Receives the triangle ramp from the far board and tracks lock, errors and last good byte.
module uart_rx_ramp_checker
  import rs232_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50000000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned ERR_W       = 16,
  parameter int unsigned RESYNC_ERRS = 4
) (
  input  logic             CLOCK_50,
  input  logic             RST_N,
  input  logic             UART_RXD,
  output logic [7:0]       RX_DATA,
  output logic             RX_VALID,
  output logic             FRAME_ERR,
  output logic             SYNCED,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic [7:0]       LEDG
);

  localparam int unsigned ConsW = $clog2(RESYNC_ERRS + 1);

  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             rx_ferr;
  chk_state_e       state_q, state_d;
  logic [7:0]       prev_q, prev_d;
  logic             prev_vld_q, prev_vld_d;
  logic             up_q, up_d;
  logic [ConsW-1:0] cons_q, cons_d;
  logic [ERR_W-1:0] err_q, err_d, err_inc;
  logic [7:0]       ledg_q, ledg_d;
  logic             synced_q, synced_d;
  logic [7:0]       exp_val;
  logic             exp_up;

  uart_rx_core #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD)
  ) u_rx (
    .clk_i      (CLOCK_50),
    .rst_ni     (RST_N),
    .rxd_i      (UART_RXD),
    .data_o     (rx_data),
    .valid_o    (rx_valid),
    .frame_err_o(rx_ferr)
  );

  // Checker state registers.
  always_ff @(posedge CLOCK_50 or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ChkHunt;
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
      up_q       <= 1'b0;
      cons_q     <= '0;
      err_q      <= '0;
      ledg_q     <= '0;
      synced_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
      up_q       <= up_d;
      cons_q     <= cons_d;
      err_q      <= err_d;
      ledg_q     <= ledg_d;
      synced_q   <= synced_d;
    end
  end

  // Expected next ramp value, with forced turnaround at the ends.
  always_comb begin
    exp_up  = up_q;
    exp_val = up_q ? prev_q + 8'd1 : prev_q - 8'd1;
    if (prev_q == 8'hFF) begin
      exp_val = 8'hFE;
      exp_up  = 1'b0;
    end else if (prev_q == 8'h00) begin
      exp_val = 8'h01;
      exp_up  = 1'b1;
    end
  end

  assign err_inc = (err_q == '1) ? err_q : err_q + ERR_W'(1);

  // Checker next-state: HUNT looks for two consecutive ramp steps, LOCKED follows the ramp.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
    up_d       = up_q;
    cons_d     = cons_q;
    err_d      = err_q;
    ledg_d     = ledg_q;
    unique case (state_q)
      ChkHunt: begin
        if (rx_valid) begin
          if (prev_vld_q && (rx_data == prev_q + 8'd1)) begin
            state_d = ChkLocked;
            up_d    = 1'b1;
            ledg_d  = rx_data;
            cons_d  = '0;
          end else if (prev_vld_q && (rx_data == prev_q - 8'd1)) begin
            state_d = ChkLocked;
            up_d    = 1'b0;
            ledg_d  = rx_data;
            cons_d  = '0;
          end
          prev_d     = rx_data;
          prev_vld_d = 1'b1;
        end else if (rx_ferr) begin
          err_d      = err_inc;
          prev_vld_d = 1'b0;
        end
      end
      ChkLocked: begin
        if (rx_valid) begin
          prev_d = rx_data;
          if (rx_data == exp_val) begin
            ledg_d = rx_data;
            cons_d = '0;
            up_d   = exp_up;
          end else begin
            err_d  = err_inc;
            cons_d = cons_q + ConsW'(1);
          end
        end else if (rx_ferr) begin
          err_d  = err_inc;
          cons_d = cons_q + ConsW'(1);
        end
        if (cons_d == ConsW'(RESYNC_ERRS)) begin
          state_d = ChkHunt;
        end
      end
      default: state_d = ChkHunt;
    endcase
    synced_d = (state_d == ChkLocked);
  end

  assign RX_DATA   = rx_data;
  assign RX_VALID  = rx_valid;
  assign FRAME_ERR = rx_ferr;
  assign SYNCED    = synced_q;
  assign ERR_COUNT = err_q;
  assign LEDG      = ledg_q;

endmodule

// File: tb/tb_uart_rx_ramp_checker.sv
// Scoreboard bench: stimulus pushes expected events from a ramp model, a monitor checks them.
module tb_uart_rx_ramp_checker;

  localparam int unsigned CLK_HZ = 800000;
  localparam int unsigned BAUD   = 100000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;
  localparam int unsigned ERR_W  = 16;
  localparam int unsigned RESYNC = 4;

  logic             CLOCK_50 = 1'b0;
  logic             RST_N    = 1'b0;
  logic             UART_RXD = 1'b1;
  logic [7:0]       RX_DATA;
  logic             RX_VALID;
  logic             FRAME_ERR;
  logic             SYNCED;
  logic [ERR_W-1:0] ERR_COUNT;
  logic [7:0]       LEDG;

  uart_rx_ramp_checker #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .ERR_W      (ERR_W),
    .RESYNC_ERRS(RESYNC)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .RST_N    (RST_N),
    .UART_RXD (UART_RXD),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .FRAME_ERR(FRAME_ERR),
    .SYNCED   (SYNCED),
    .ERR_COUNT(ERR_COUNT),
    .LEDG     (LEDG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit               is_valid;
    logic [7:0]       data;
    logic             synced;
    logic [ERR_W-1:0] err;
    logic [7:0]       ledg;
    int               start_cyc;
  } ev_t;

  ev_t exp_q[$];

  // Reference model of the link as seen from the far end.
  bit               m_have;
  logic [7:0]       m_prev;
  bit               m_locked;
  bit               m_up;
  int               m_cons;
  logic [ERR_W-1:0] m_err;
  logic [7:0]       m_ledg;
  logic [7:0]       m_rxdata;

  task automatic model_reset();
    m_have = 0; m_prev = '0; m_locked = 0; m_up = 0; m_cons = 0;
    m_err = '0; m_ledg = '0; m_rxdata = '0;
  endtask

  // Triangle ramp successor: {direction, value}.
  function automatic logic [8:0] ramp_after(input logic [7:0] p, input bit up);
    if (p == 8'hFF) return {1'b0, 8'hFE};
    if (p == 8'h00) return {1'b1, 8'h01};
    return up ? {1'b1, p + 8'd1} : {1'b0, p - 8'd1};
  endfunction

  task automatic bump_err();
    if (m_err != '1) m_err = m_err + 1'b1;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit stop, output ev_t e);
    logic [8:0] nx;
    if (!stop) begin
      bump_err();
      if (m_locked) begin
        m_cons++;
        if (m_cons == RESYNC) m_locked = 0;
      end else begin
        m_have = 0;
      end
    end else begin
      m_rxdata = b;
      if (!m_locked) begin
        if (m_have && b == m_prev + 8'd1) begin
          m_locked = 1; m_up = 1; m_ledg = b; m_cons = 0;
        end else if (m_have && b == m_prev - 8'd1) begin
          m_locked = 1; m_up = 0; m_ledg = b; m_cons = 0;
        end
        m_have = 1;
      end else begin
        nx = ramp_after(m_prev, m_up);
        if (b == nx[7:0]) begin
          m_ledg = b; m_cons = 0; m_up = nx[8];
        end else begin
          bump_err();
          m_cons++;
          if (m_cons == RESYNC) m_locked = 0;
        end
      end
      m_prev = b;
    end
    e.is_valid  = stop;
    e.data      = m_rxdata;
    e.synced    = m_locked;
    e.err       = m_err;
    e.ledg      = m_ledg;
    e.start_cyc = 0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rx_data"}, {24'd0, RX_DATA}, 32'd0);
    check({tag, "_rx_valid"}, {31'd0, RX_VALID}, 32'd0);
    check({tag, "_frame_err"}, {31'd0, FRAME_ERR}, 32'd0);
    check({tag, "_synced"}, {31'd0, SYNCED}, 32'd0);
    check({tag, "_err_count"}, {16'd0, ERR_COUNT}, 32'd0);
    check({tag, "_ledg"}, {24'd0, LEDG}, 32'd0);
  endtask

  // Called at posedge+1; holds the line for one bit period.
  task automatic drive_bit(input logic v);
    UART_RXD = v;
    repeat (DIV) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic idle(input int n);
    UART_RXD = 1'b1;
    repeat (n) @(posedge CLOCK_50);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop);
    ev_t e;
    model_byte(b, stop, e);
    e.start_cyc = cyc;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    if (!stop) drive_bit(1'b1);
    idle($urandom_range(2, 6));
  endtask

  // Monitor: pop on every pulse, check pulse/data/latency, then checker outputs a cycle later.
  initial begin
    ev_t e;
    int  lat;
    forever begin
      @(negedge CLOCK_50);
      if (RST_N && (RX_VALID || FRAME_ERR)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", {30'd0, RX_VALID, FRAME_ERR}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          lat = cyc - e.start_cyc;
          check("rx_valid", {31'd0, RX_VALID}, {31'd0, e.is_valid});
          check("frame_err", {31'd0, FRAME_ERR}, {31'd0, !e.is_valid});
          check("rx_data", {24'd0, RX_DATA}, {24'd0, e.data});
          check("latency_in_window", {31'd0, (lat >= 9 * DIV) && (lat <= 10 * DIV + 2)}, 32'd1);
          @(negedge CLOCK_50);
          check("pulse_width", {30'd0, RX_VALID, FRAME_ERR}, 32'd0);
          check("synced", {31'd0, SYNCED}, {31'd0, e.synced});
          check("err_count", {16'd0, ERR_COUNT}, {16'd0, e.err});
          check("ledg", {24'd0, LEDG}, {24'd0, e.ledg});
        end
      end
    end
  end

  initial begin
    logic [7:0] v;
    logic [8:0] nx;
    bit         up;
    int         r;

    model_reset();
    repeat (3) @(posedge CLOCK_50);
    #1;
    check_all_zero("reset");
    RST_N = 1'b1;
    idle(5);

    // Single frame, HUNT just loads prev.
    send_byte(8'h55, 1'b1);

    // Full triangle ramp including both turnarounds.
    for (int i = 1; i <= 255; i++) send_byte(8'(i), 1'b1);
    for (int i = 254; i >= 0; i--) send_byte(8'(i), 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);

    // Single skipped value while locked up.
    for (int i = 3; i <= 'h11; i++) send_byte(8'(i), 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h14, 1'b1);

    // Framing error, then a good byte clears the run.
    send_byte(8'hA5, 1'b0);
    send_byte(8'h15, 1'b1);

    // Short low glitch shorter than half a bit must be ignored.
    UART_RXD = 1'b0;
    repeat (DIV / 2 - 2) @(posedge CLOCK_50);
    #1;
    idle(2 * DIV);

    // Four unrelated bytes drop lock.
    send_byte(8'h80, 1'b1);
    send_byte(8'h20, 1'b1);
    send_byte(8'h60, 1'b1);
    send_byte(8'hC3, 1'b1);

    // Randomised ramp segments with injected bad bytes and framing errors.
    v  = 8'($urandom_range(0, 255));
    up = 1'($urandom_range(0, 1));
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 99);
      if (r < 75) begin
        nx = ramp_after(v, up);
        v  = nx[7:0];
        up = nx[8];
        send_byte(v, 1'b1);
      end else if (r < 90) begin
        send_byte(8'($urandom_range(0, 255)), 1'b1);
      end else begin
        send_byte(8'($urandom_range(0, 255)), 1'b0);
      end
    end

    // Reset in the middle of a frame (during bit 3).
    idle(3 * DIV);
    check("queue_drained_before_reset", exp_q.size(), 32'd0);
    v = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(v[i]);
    UART_RXD = v[3];
    repeat (DIV / 2) @(posedge CLOCK_50);
    #1;
    RST_N = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    model_reset();
    idle(3);
    RST_N = 1'b1;
    idle(3 * DIV);
    send_byte(8'h3C, 1'b1);
    idle(3 * DIV);
    check("synced_after_reset_frame", {31'd0, SYNCED}, 32'd0);

    check("queue_drained", exp_q.size(), 32'd0);
    check("final_err_count", {16'd0, ERR_COUNT}, {16'd0, m_err});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
